// File: rtl/uart_cfg_if.sv
// Client-side bundle of uart_cfg: transmit handshake, receive handshake and
// the status flags that travel with each received frame.
interface uart_cfg_if #(
  parameter int DBIT = 8
);
  logic [DBIT-1:0] tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic            tx_done_tick;
  logic [DBIT-1:0] rx_data;
  logic            rx_valid;
  logic            rx_ready;
  logic            rx_parity_err;
  logic            rx_frame_err;
  logic            rx_overrun;

  // Byte-stream client (CPU or bus bridge) view.
  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, tx_done_tick, rx_data, rx_valid,
    input  rx_parity_err, rx_frame_err, rx_overrun
  );

  // UART core view.
  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, tx_done_tick, rx_data, rx_valid,
    output rx_parity_err, rx_frame_err, rx_overrun
  );
endinterface

// File: rtl/uart_cfg.sv
// Full-duplex UART with runtime frame format (data bits, parity, stop bits),
// shared oversampling baud tick, valid/ready client handshakes, error flags
// and an internal tx->rx loopback.
module uart_cfg #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR_W  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DVSR_W-1:0]     dvsr,
  input  logic [$clog2(DBIT):0] cfg_dbits,
  input  logic [1:0]            cfg_parity,
  input  logic                  cfg_stop2,
  input  logic                  loopback,
  output logic                  tx,
  input  logic                  rx,
  uart_cfg_if.slave             bus
);

  localparam int CW = $clog2(DBIT) + 1;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int SW = $clog2(2 * SB_TICK);

  // Tick-count values: end of one bit, mid start bit, end of two stop bits.
  localparam logic [SW-1:0] BIT_LAST   = SW'(SB_TICK - 1);
  localparam logic [SW-1:0] HALF_LAST  = SW'(SB_TICK / 2 - 1);
  localparam logic [SW-1:0] STOP2_LAST = SW'(2 * SB_TICK - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // ---------------------------------------------------------------- baud
  logic [DVSR_W-1:0] baud_cnt_reg;
  logic              s_tick;

  assign s_tick = (baud_cnt_reg == dvsr);

  // Divisor counter: 0..dvsr then wrap; also recovers if dvsr shrinks below it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt_reg <= '0;
    end else if (baud_cnt_reg >= dvsr) begin
      baud_cnt_reg <= '0;
    end else begin
      baud_cnt_reg <= baud_cnt_reg + 1'b1;
    end
  end

  // ------------------------------------------------------- config decode
  logic [NW-1:0]   cfg_last;
  logic            cfg_par_en;
  logic            cfg_par_odd;
  logic [DBIT-1:0] cfg_mask;

  // Index of the last data bit; out-of-range lengths fall back to DBIT bits.
  always_comb begin
    cfg_last = NW'(DBIT - 1);
    if (cfg_dbits != '0 && cfg_dbits <= CW'(DBIT)) begin
      cfg_last = NW'(cfg_dbits - 1'b1);
    end
  end

  assign cfg_par_en  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
  assign cfg_par_odd = (cfg_parity == 2'b10);

  // Keep only the bits that belong to the configured frame length.
  for (genvar gi = 0; gi < DBIT; gi++) begin : g_mask
    assign cfg_mask[gi] = (NW'(gi) <= cfg_last);
  end

  // ------------------------------------------------------------ transmit
  state_t          tx_state_reg;
  logic [SW-1:0]   tx_s_reg;
  logic [NW-1:0]   tx_n_reg;
  logic [NW-1:0]   tx_last_reg;
  logic [DBIT-1:0] tx_sh_reg;
  logic [DBIT-1:0] tx_sh_next;
  logic [DBIT-1:0] tx_masked;
  logic            tx_par_en_reg;
  logic            tx_par_bit_reg;
  logic            tx_stop2_reg;
  logic            tx_reg;
  logic            tx_ready_reg;
  logic            tx_done_reg;

  assign tx_sh_next = tx_sh_reg >> 1;
  assign tx_masked  = bus.tx_data & cfg_mask;

  // TX FSM; the line level, ready and done pulse are all registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_reg   <= IDLE;
      tx_s_reg       <= '0;
      tx_n_reg       <= '0;
      tx_last_reg    <= '0;
      tx_sh_reg      <= '0;
      tx_par_en_reg  <= 1'b0;
      tx_par_bit_reg <= 1'b0;
      tx_stop2_reg   <= 1'b0;
      tx_reg         <= 1'b1;
      tx_ready_reg   <= 1'b1;
      tx_done_reg    <= 1'b0;
    end else begin
      tx_done_reg <= 1'b0;
      case (tx_state_reg)
        IDLE: begin
          if (bus.tx_valid && tx_ready_reg) begin
            // Frame format is frozen here for the whole frame.
            tx_sh_reg      <= tx_masked;
            tx_last_reg    <= cfg_last;
            tx_par_en_reg  <= cfg_par_en;
            tx_par_bit_reg <= (^tx_masked) ^ cfg_par_odd;
            tx_stop2_reg   <= cfg_stop2;
            tx_s_reg       <= '0;
            tx_n_reg       <= '0;
            tx_reg         <= 1'b0;
            tx_ready_reg   <= 1'b0;
            tx_state_reg   <= START;
          end
        end
        START: begin
          if (s_tick) begin
            if (tx_s_reg == BIT_LAST) begin
              tx_s_reg     <= '0;
              tx_reg       <= tx_sh_reg[0];
              tx_state_reg <= DATA;
            end else begin
              tx_s_reg <= tx_s_reg + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (tx_s_reg == BIT_LAST) begin
              tx_s_reg  <= '0;
              tx_sh_reg <= tx_sh_next;
              if (tx_n_reg == tx_last_reg) begin
                if (tx_par_en_reg) begin
                  tx_reg       <= tx_par_bit_reg;
                  tx_state_reg <= PARITY;
                end else begin
                  tx_reg       <= 1'b1;
                  tx_state_reg <= STOP;
                end
              end else begin
                tx_n_reg <= tx_n_reg + 1'b1;
                tx_reg   <= tx_sh_next[0];
              end
            end else begin
              tx_s_reg <= tx_s_reg + 1'b1;
            end
          end
        end
        PARITY: begin
          if (s_tick) begin
            if (tx_s_reg == BIT_LAST) begin
              tx_s_reg     <= '0;
              tx_reg       <= 1'b1;
              tx_state_reg <= STOP;
            end else begin
              tx_s_reg <= tx_s_reg + 1'b1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            // Two stop bits are simply one stop interval twice as long.
            if (tx_s_reg == (tx_stop2_reg ? STOP2_LAST : BIT_LAST)) begin
              tx_s_reg     <= '0;
              tx_done_reg  <= 1'b1;
              tx_ready_reg <= 1'b1;
              tx_state_reg <= IDLE;
            end else begin
              tx_s_reg <= tx_s_reg + 1'b1;
            end
          end
        end
        default: begin
          tx_reg       <= 1'b1;
          tx_ready_reg <= 1'b1;
          tx_state_reg <= IDLE;
        end
      endcase
    end
  end

  assign tx               = loopback ? 1'b1 : tx_reg;
  assign bus.tx_ready     = tx_ready_reg;
  assign bus.tx_done_tick = tx_done_reg;

  // ------------------------------------------------------------- receive
  logic rx_sync1_reg;
  logic rx_sync2_reg;
  logic rx_line;

  // Two-flop synchroniser for the asynchronous pin; idles at the mark level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync1_reg <= 1'b1;
      rx_sync2_reg <= 1'b1;
    end else begin
      rx_sync1_reg <= rx;
      rx_sync2_reg <= rx_sync1_reg;
    end
  end

  // The internal tx line is already synchronous, so loopback skips the flops.
  assign rx_line = loopback ? tx_reg : rx_sync2_reg;

  state_t          rx_state_reg;
  logic [SW-1:0]   rx_s_reg;
  logic [NW-1:0]   rx_n_reg;
  logic [NW-1:0]   rx_last_reg;
  logic            rx_par_en_reg;
  logic            rx_par_odd_reg;
  logic            rx_stop2_reg;
  logic            rx_stop_n_reg;
  logic [DBIT-1:0] rx_shift_reg;
  logic            rx_perr_reg;
  logic            rx_ferr_reg;
  logic [DBIT-1:0] rx_data_reg;
  logic            rx_valid_reg;
  logic            rx_parity_err_reg;
  logic            rx_frame_err_reg;
  logic            rx_overrun_reg;

  // RX FSM plus holding register; a commit overrides a same-cycle consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_reg      <= IDLE;
      rx_s_reg          <= '0;
      rx_n_reg          <= '0;
      rx_last_reg       <= '0;
      rx_par_en_reg     <= 1'b0;
      rx_par_odd_reg    <= 1'b0;
      rx_stop2_reg      <= 1'b0;
      rx_stop_n_reg     <= 1'b0;
      rx_shift_reg      <= '0;
      rx_perr_reg       <= 1'b0;
      rx_ferr_reg       <= 1'b0;
      rx_data_reg       <= '0;
      rx_valid_reg      <= 1'b0;
      rx_parity_err_reg <= 1'b0;
      rx_frame_err_reg  <= 1'b0;
      rx_overrun_reg    <= 1'b0;
    end else begin
      if (rx_valid_reg && bus.rx_ready) begin
        rx_valid_reg      <= 1'b0;
        rx_parity_err_reg <= 1'b0;
        rx_frame_err_reg  <= 1'b0;
        rx_overrun_reg    <= 1'b0;
      end
      case (rx_state_reg)
        IDLE: begin
          if (!rx_line) begin
            rx_last_reg    <= cfg_last;
            rx_par_en_reg  <= cfg_par_en;
            rx_par_odd_reg <= cfg_par_odd;
            rx_stop2_reg   <= cfg_stop2;
            rx_stop_n_reg  <= 1'b0;
            rx_shift_reg   <= '0;
            rx_perr_reg    <= 1'b0;
            rx_ferr_reg    <= 1'b0;
            rx_s_reg       <= '0;
            rx_n_reg       <= '0;
            rx_state_reg   <= START;
          end
        end
        START: begin
          if (s_tick) begin
            if (rx_s_reg == HALF_LAST) begin
              // Mid start bit: still low means a real frame, else a glitch.
              rx_s_reg     <= '0;
              rx_state_reg <= rx_line ? IDLE : DATA;
            end else begin
              rx_s_reg <= rx_s_reg + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (rx_s_reg == BIT_LAST) begin
              rx_s_reg               <= '0;
              rx_shift_reg[rx_n_reg] <= rx_line;
              if (rx_n_reg == rx_last_reg) begin
                rx_state_reg <= rx_par_en_reg ? PARITY : STOP;
              end else begin
                rx_n_reg <= rx_n_reg + 1'b1;
              end
            end else begin
              rx_s_reg <= rx_s_reg + 1'b1;
            end
          end
        end
        PARITY: begin
          if (s_tick) begin
            if (rx_s_reg == BIT_LAST) begin
              rx_s_reg     <= '0;
              rx_perr_reg  <= rx_line ^ (^rx_shift_reg) ^ rx_par_odd_reg;
              rx_state_reg <= STOP;
            end else begin
              rx_s_reg <= rx_s_reg + 1'b1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (rx_s_reg == BIT_LAST) begin
              rx_s_reg <= '0;
              if (!rx_stop2_reg || rx_stop_n_reg) begin
                // Commit right at the last stop sample so back-to-back frames fit.
                rx_data_reg       <= rx_shift_reg;
                rx_parity_err_reg <= rx_perr_reg;
                rx_frame_err_reg  <= rx_ferr_reg | ~rx_line;
                rx_overrun_reg    <= rx_valid_reg & ~bus.rx_ready;
                rx_valid_reg      <= 1'b1;
                rx_state_reg      <= IDLE;
              end else begin
                rx_ferr_reg   <= rx_ferr_reg | ~rx_line;
                rx_stop_n_reg <= 1'b1;
              end
            end else begin
              rx_s_reg <= rx_s_reg + 1'b1;
            end
          end
        end
        default: begin
          rx_state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.rx_data       = rx_data_reg;
  assign bus.rx_valid      = rx_valid_reg;
  assign bus.rx_parity_err = rx_parity_err_reg;
  assign bus.rx_frame_err  = rx_frame_err_reg;
  assign bus.rx_overrun    = rx_overrun_reg;

endmodule
